// File: rtl/uart_cmd_reader.sv
// UART 8N1 receiver plus command-line assembler that presents a whole CR-terminated line.
// Latency: cmd_valid rises on the cycle after the CR stop-bit sample; bytes land one cycle after their stop sample.
// Backpressure: while cmd_valid is held without ack, received bytes are discarded; RX keeps running.
module uart_cmd_reader #(
  parameter int CLKS_PER_BIT = 234,
  parameter int CMD_MAX      = 8,
  localparam int LW          = $clog2(CMD_MAX + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 enable,
  input  logic                 cmd_ack,
  output logic                 cmd_valid,
  output logic [LW-1:0]        cmd_len,
  output logic [8*CMD_MAX-1:0] cmd_data,
  output logic [1:0]           cmd_error,
  output logic                 rx_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(8 * CMD_MAX);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  rx_state_t     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_idx, bit_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          rx_meta, rx_sync;
  logic [1:0]    sync_fill;
  logic          armed;
  logic          byte_done, frame_err;
  logic [IW-1:0] wr_idx, bs_idx;

  assign rx_busy = (state != IDLE);
  assign wr_idx  = IW'(8 * int'(cmd_len));
  assign bs_idx  = IW'(8 * (int'(cmd_len) - 1));

  // Two-flop synchroniser; armed only once a genuine idle-high has passed through it after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      sync_fill <= 2'b00;
      armed     <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rx_sync   <= rx_meta;
      sync_fill <= {sync_fill[0], 1'b1};
      armed     <= armed | (sync_fill[1] & rx_sync);
    end
  end

  // RX state register with bit counter, bit index and shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_nxt;
      shift   <= shift_nxt;
    end
  end

  // RX next state: sample mid-bit, LSB first, leave at mid-stop so frames can run back to back
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bit_nxt   = bit_idx;
    shift_nxt = shift;
    byte_done = 1'b0;
    frame_err = 1'b0;
    case (state)
      IDLE: begin
        if (armed && !rx_sync) begin
          state_nxt = START;
          cnt_nxt   = '0;
        end
      end
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_nxt   = '0;
          bit_nxt   = '0;
          state_nxt = rx_sync ? IDLE : DATA;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt   = '0;
          shift_nxt = {rx_sync, shift[7:1]};
          if (bit_idx == 3'd7) state_nxt = STOP;
          else                 bit_nxt   = bit_idx + 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
          if (rx_sync) byte_done = 1'b1;
          else         frame_err = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Line assembler and valid/ack handshake; first fault in a line is the one reported
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid <= 1'b0;
      cmd_len   <= '0;
      cmd_data  <= '0;
      cmd_error <= 2'd0;
    end else if (!enable || (cmd_valid && cmd_ack)) begin
      cmd_valid <= 1'b0;
      cmd_len   <= '0;
      cmd_data  <= '0;
      cmd_error <= 2'd0;
    end else if (!cmd_valid) begin
      if (frame_err) begin
        if (cmd_error == 2'd0) cmd_error <= 2'd2;
      end else if (byte_done) begin
        case (shift)
          8'h0D: begin
            if (cmd_len != '0 || cmd_error != 2'd0) cmd_valid <= 1'b1;
          end
          8'h0A: ;
          8'h08, 8'h7F: begin
            if (cmd_len != '0) begin
              cmd_data[bs_idx +: 8] <= 8'h00;
              cmd_len               <= cmd_len - 1'b1;
            end
          end
          default: begin
            if (cmd_len < LW'(CMD_MAX)) begin
              cmd_data[wr_idx +: 8] <= shift;
              cmd_len               <= cmd_len + 1'b1;
            end else if (cmd_error == 2'd0) begin
              cmd_error <= 2'd1;
            end
          end
        endcase
      end
    end
  end

endmodule
